mc_ctrl_unit: RTL

//  Multi-cycle MIPS-subset control unit sitting directly downstream of instruction fetch (PC + ROM_B).

---
 rtl/mc_ctrl_unit_pkg.sv | 60 ++++++
 rtl/mc_ctrl_unit_inst_decoder.sv | 45 ++++
 rtl/mc_ctrl_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, functs, state codes, ALU/PC-source codes.
package mc_ctrl_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_NOR = 3'b011,
        ALU_ADD = 3'b100,
        ALU_SUB = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PCS_INC = 2'b00,
        PCS_BR  = 2'b01,
        PCS_JMP = 2'b10
    } pc_s_t;

    typedef enum logic [2:0] {
        IC_R, IC_ALUI, IC_LW, IC_SW, IC_BEQ, IC_BNE, IC_J, IC_ILL
    } iclass_t;

    // Classes whose second ALU operand is the extended imm16.
    function automatic logic uses_imm(input iclass_t c);
        return (c == IC_ALUI) || (c == IC_LW) || (c == IC_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_unit_inst_decoder.sv
// Combinational decode of opcode/funct into instruction class, ALU operation and imm extension mode.
module mc_ctrl_unit_inst_decoder
    import mc_ctrl_unit_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output alu_op_t    alu_op,
    output logic       imm_s
);

    always_comb begin
        iclass = IC_ILL;
        alu_op = ALU_AND;
        imm_s  = 1'b0;
        case (op)
            OP_RTYPE: begin
                iclass = IC_R;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    default: iclass = IC_ILL;
                endcase
            end
            OP_ADDI: begin iclass = IC_ALUI; alu_op = ALU_ADD; imm_s = 1'b1; end
            OP_SLTI: begin iclass = IC_ALUI; alu_op = ALU_SLT; imm_s = 1'b1; end
            OP_ANDI: begin iclass = IC_ALUI; alu_op = ALU_AND; end
            OP_ORI:  begin iclass = IC_ALUI; alu_op = ALU_OR;  end
            OP_XORI: begin iclass = IC_ALUI; alu_op = ALU_XOR; end
            OP_LW:   begin iclass = IC_LW;   alu_op = ALU_ADD; imm_s = 1'b1; end
            OP_SW:   begin iclass = IC_SW;   alu_op = ALU_ADD; imm_s = 1'b1; end
            OP_BEQ:  begin iclass = IC_BEQ;  alu_op = ALU_SUB; end
            OP_BNE:  begin iclass = IC_BNE;  alu_op = ALU_SUB; end
            OP_J:    iclass = IC_J;
            default: iclass = IC_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS-subset control unit: IR latch, IF/ID/EXE/MEM/WB sequencing, Moore strobe decode.
// Optional ILLEGAL_INST_TRAP_EN: undefined instructions enter a sticky trap state instead of acting as NOPs.
module mc_ctrl_unit
    import mc_ctrl_unit_pkg::*;
#(
    parameter logic [31:0] IR_RST = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst_code,
    input  logic        ZF,
    output logic [31:0] IR,
    output logic        PC_Write,
    output logic [1:0]  PC_s,
    output logic        IR_Write,
    output logic        Reg_Write,
    output logic        Mem_Write,
    output logic [2:0]  ALU_OP,
    output logic        ALU_SrcB,
    output logic        imm_s,
    output logic        w_r_s,
    output logic        wr_data_s,
    output logic [2:0]  state,
    output logic        trap
);

    state_t      state_q;
    logic [31:0] ir_q;
    iclass_t     dec_class;
    alu_op_t     dec_alu_op;
    logic        dec_imm_s;

    mc_ctrl_unit_inst_decoder u_dec (
        .op     (ir_q[31:26]),
        .funct  (ir_q[5:0]),
        .iclass (dec_class),
        .alu_op (dec_alu_op),
        .imm_s  (dec_imm_s)
    );

`ifdef ILLEGAL_INST_TRAP_EN
    logic trap_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IF;
            ir_q    <= IR_RST;
`ifdef ILLEGAL_INST_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IF: begin
                    ir_q    <= Inst_code;
                    state_q <= S_ID;
                end
                S_ID: begin
                    case (dec_class)
                        IC_J: state_q <= S_IF;
                        IC_ILL: begin
`ifdef ILLEGAL_INST_TRAP_EN
                            state_q <= S_TRAP;
                            trap_q  <= 1'b1;
`else
                            state_q <= S_IF;
`endif
                        end
                        default: state_q <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (dec_class)
                        IC_R, IC_ALUI: state_q <= S_WB;
                        IC_LW, IC_SW:  state_q <= S_MEM;
                        default:       state_q <= S_IF;
                    endcase
                end
                S_MEM:   state_q <= (dec_class == IC_LW) ? S_WB : S_IF;
                S_WB:    state_q <= S_IF;
`ifdef ILLEGAL_INST_TRAP_EN
                S_TRAP:  state_q <= S_TRAP;
`endif
                default: state_q <= S_IF;
            endcase
        end
    end

`ifdef ILLEGAL_INST_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign IR    = ir_q;
    assign state = state_q;

    // Strobes are silenced combinationally while reset is held so an abandoned instruction cannot write.
    always_comb begin
        PC_Write  = 1'b0;
        PC_s      = PCS_INC;
        IR_Write  = 1'b0;
        Reg_Write = 1'b0;
        Mem_Write = 1'b0;
        ALU_OP    = ALU_AND;
        ALU_SrcB  = 1'b0;
        imm_s     = 1'b0;
        w_r_s     = 1'b0;
        wr_data_s = 1'b0;
        if (rst) begin
            case (state_q)
                S_IF: begin
                    IR_Write = 1'b1;
                    PC_Write = 1'b1;
                end
                S_ID: begin
                    if (dec_class == IC_J) begin
                        PC_Write = 1'b1;
                        PC_s     = PCS_JMP;
                    end
                end
                S_EXE: begin
                    ALU_OP   = dec_alu_op;
                    ALU_SrcB = uses_imm(dec_class);
                    imm_s    = dec_imm_s;
                    if (dec_class == IC_BEQ) begin
                        PC_Write = ZF;
                        PC_s     = PCS_BR;
                    end else if (dec_class == IC_BNE) begin
                        PC_Write = ~ZF;
                        PC_s     = PCS_BR;
                    end
                end
                S_MEM: Mem_Write = (dec_class == IC_SW);
                S_WB: begin
                    Reg_Write = 1'b1;
                    w_r_s     = (dec_class == IC_R);
                    wr_data_s = (dec_class == IC_LW);
                end
                default: ;
            endcase
        end
    end

endmodule
